disk_read_arbiter: RTL

- Parametrised successor to the fixed three-source read mux in front of the RAID disk memories.
- Accepts read requests from N_REQ requesters (normal read, write parity-read, RAID rebuild, ...) with fair round-robin arbitration.
- Issues one memory read at a time to N_DISK disks, waits for the memory's completion strobe, and routes the returned data back to the requester that was granted.
- Adds a per-transaction timeout and an error response, which the fixed mux did not have.

---
 rtl/disk_read_arbiter_pkg.sv | 31 +++
 rtl/disk_read_arbiter_rr_arbiter.sv | 36 +++
 rtl/disk_read_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/disk_read_arbiter_pkg.sv
// Shared types and helpers for the disk read arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package disk_rd_pkg;

  // Transaction FSM: pick a requester, issue the read, wait for the disks, respond.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rd_state_t;

  // Default geometry: two Hamming-encoded 12-bit disk words, 256-word memories.
  localparam int DEFAULT_DW     = 12;
  localparam int DEFAULT_AW     = 8;
  localparam int DEFAULT_N_DISK = 2;

  // Timeout counter width; covers TIMEOUT up to 255.
  localparam int CNT_W = 8;

  // Bit bit_idx of the data lane mask: set when the disk owning that bit
  // (lane bit_idx / dw) is enabled in en. Callers build the full
  // N_DISK*DW mask one bit at a time so the helper stays width-agnostic.
  function automatic logic lane_mask_bit(input logic [31:0] en,
                                         input int          bit_idx,
                                         input int          dw);
    return ((en >> (bit_idx / dw)) & 32'd1) != 32'd0;
  endfunction

endpackage

// File: rtl/disk_read_arbiter_rr_arbiter.sv
// Round-robin winner search: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller samples the result only when it can accept.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   cand;

  // Walk the requesters starting at ptr and keep the first one that is asking.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req[IW'(cand)]) begin
        found            = 1'b1;
        gnt[IW'(cand)]   = 1'b1;
        idx              = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/disk_read_arbiter.sv
// Round-robin read arbiter: N_REQ requesters share one read port to N_DISK disk memories.
// Latency: grant/command 1 cycle after request sampled; response 1 cycle after mem_rd_valid or after TIMEOUT wait cycles.
// Backpressure: one transaction outstanding; other requesters hold req_valid until their req_ready pulse.
module disk_read_arbiter #(
  parameter int N_REQ   = 3,
  parameter int DW      = disk_rd_pkg::DEFAULT_DW,
  parameter int AW      = disk_rd_pkg::DEFAULT_AW,
  parameter int N_DISK  = disk_rd_pkg::DEFAULT_N_DISK,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*AW-1:0]    req_addr,
  input  logic [N_REQ*N_DISK-1:0] req_en,
  output logic [N_REQ-1:0]       req_ready,
  output logic [AW-1:0]          mem_address,
  output logic [N_DISK-1:0]      mem_en_rd,
  input  logic                   mem_rd_valid,
  input  logic [N_DISK*DW-1:0]   mem_rd_data,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [N_DISK*DW-1:0]   rsp_data,
  output logic                   rsp_err,
  output logic                   busy
);

  import disk_rd_pkg::*;

  localparam int IW = $clog2(N_REQ);
  localparam int LW = N_DISK * DW;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  // Current transaction context.
  rd_state_t         state,    state_n;
  logic [IW-1:0]     rr_ptr,   rr_ptr_n;
  logic [IW-1:0]     gnt_idx,  gnt_idx_n;
  logic [N_REQ-1:0]  gnt_oh,   gnt_oh_n;
  logic [AW-1:0]     lat_addr, lat_addr_n;
  logic [N_DISK-1:0] lat_en,   lat_en_n;
  logic [LW-1:0]     lat_data, lat_data_n;
  logic              lat_err,  lat_err_n;
  logic [CNT_W-1:0]  cnt,      cnt_n, cnt_inc;

  // Next values of the registered outputs.
  logic [N_REQ-1:0]  req_ready_n;
  logic [AW-1:0]     mem_address_n;
  logic [N_DISK-1:0] mem_en_rd_n;
  logic [N_REQ-1:0]  rsp_valid_n;
  logic [LW-1:0]     rsp_data_n;
  logic              rsp_err_n;
  logic              busy_n;

  // Per-requester views of the flattened request buses.
  logic [AW-1:0]     addr_arr [N_REQ];
  logic [N_DISK-1:0] en_arr   [N_REQ];
  logic [N_REQ-1:0]  arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic [LW-1:0]     data_mask;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign addr_arr[i] = req_addr[i*AW +: AW];
    assign en_arr[i]   = req_en[i*N_DISK +: N_DISK];
  end

  // Disabled disks return whatever is on their bus; zero those lanes.
  for (genvar b = 0; b < LW; b++) begin : g_mask
    assign data_mask[b] = lane_mask_bit(32'(lat_en), b, DW);
  end

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Next-state logic, then the outputs that belong to the state being entered
  // (outputs are registered, so they are decided one cycle ahead).
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    gnt_idx_n  = gnt_idx;
    gnt_oh_n   = gnt_oh;
    lat_addr_n = lat_addr;
    lat_en_n   = lat_en;
    lat_data_n = lat_data;
    lat_err_n  = lat_err;
    cnt_n      = cnt;
    cnt_inc    = cnt + CNT_W'(1);

    req_ready_n   = '0;
    mem_address_n = '0;
    mem_en_rd_n   = '0;
    rsp_valid_n   = '0;
    rsp_data_n    = '0;
    rsp_err_n     = 1'b0;
    busy_n        = 1'b0;

    case (state)
      IDLE: begin
        if (|req_valid) begin
          gnt_idx_n  = arb_idx;
          gnt_oh_n   = arb_gnt;
          lat_addr_n = addr_arr[arb_idx];
          lat_en_n   = en_arr[arb_idx];
          if (|en_arr[arb_idx]) begin
            state_n = ISSUE;
          end else begin
            // Nothing to read: answer straight away with an empty, good response.
            state_n    = RESP;
            lat_data_n = '0;
            lat_err_n  = 1'b0;
          end
        end
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = '0;
      end
      WAIT: begin
        // A completion on the final counted cycle still wins over the timeout.
        if (mem_rd_valid) begin
          lat_data_n = mem_rd_data & data_mask;
          lat_err_n  = 1'b0;
          state_n    = RESP;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            lat_data_n = '0;
            lat_err_n  = 1'b1;
            state_n    = RESP;
          end
        end
      end
      RESP: begin
        rr_ptr_n = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
    case (state_n)
      ISSUE: begin
        req_ready_n   = gnt_oh_n;
        mem_address_n = lat_addr_n;
        mem_en_rd_n   = lat_en_n;
      end
      RESP: begin
        rsp_valid_n = gnt_oh_n;
        rsp_data_n  = lat_data_n;
        rsp_err_n   = lat_err_n;
        // The zero-mask path never visits ISSUE, so the accept pulse goes out here.
        if (lat_en_n == '0) begin
          req_ready_n = gnt_oh_n;
        end
      end
      default: ;
    endcase
  end

  // State, transaction context and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      gnt_oh      <= '0;
      lat_addr    <= '0;
      lat_en      <= '0;
      lat_data    <= '0;
      lat_err     <= 1'b0;
      cnt         <= '0;
      req_ready   <= '0;
      mem_address <= '0;
      mem_en_rd   <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      gnt_idx     <= gnt_idx_n;
      gnt_oh      <= gnt_oh_n;
      lat_addr    <= lat_addr_n;
      lat_en      <= lat_en_n;
      lat_data    <= lat_data_n;
      lat_err     <= lat_err_n;
      cnt         <= cnt_n;
      req_ready   <= req_ready_n;
      mem_address <= mem_address_n;
      mem_en_rd   <= mem_en_rd_n;
      rsp_valid   <= rsp_valid_n;
      rsp_data    <= rsp_data_n;
      rsp_err     <= rsp_err_n;
      busy        <= busy_n;
    end
  end

endmodule
